// File: rtl/matmul_sequencer.sv
// matmul_sequencer: forward-pass sequencer for the MAC-array datapath.
// One FORWARD command is tiled over NU_COUNT MAC units. Each tile runs
// LOAD (clear), ACCUM (length0 reads), DRAIN (READ_LAT cycles) and
// WRITE (one y write per output of the tile). A HALT command makes the
// block ignore all further commands until the next reset.
module matmul_sequencer #(
    parameter int NU_COUNT     = 4,
    parameter int XY_MEM_DEPTH = 8,
    parameter int W_MEM_DEPTH  = 10,
    parameter int LENGTH_DEPTH = 8,
    parameter int READ_LAT     = 1,
    localparam int SEL_W       = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              instruction,
    input  logic [XY_MEM_DEPTH-1:0] x_addr,
    input  logic [XY_MEM_DEPTH-1:0] y_addr,
    input  logic [W_MEM_DEPTH-1:0]  w_addr,
    input  logic [LENGTH_DEPTH-1:0] length0,
    input  logic [LENGTH_DEPTH-1:0] length1,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    halted,
    output logic [XY_MEM_DEPTH-1:0] xy_read_addr,
    output logic [W_MEM_DEPTH-1:0]  w_read_addr,
    output logic                    mac_clear,
    output logic                    mac_acc_en,
    output logic [SEL_W-1:0]        mac_sel,
    output logic [XY_MEM_DEPTH-1:0] xy_write_addr,
    output logic                    xy_write_en
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] INS_HALT    = 2'd0;
    localparam logic [1:0] INS_FORWARD = 2'd1;

    localparam int DRAIN_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [DRAIN_W-1:0]      DRAIN_LAST = DRAIN_W'(READ_LAT - 1);
    localparam logic [LENGTH_DEPTH-1:0] NU_L       = LENGTH_DEPTH'(NU_COUNT);
    localparam logic [LENGTH_DEPTH-1:0] ONE_L      = LENGTH_DEPTH'(1);

    logic [2:0]              state_reg;
    logic [2:0]              state_next;
    logic                    halted_reg;
    logic [XY_MEM_DEPTH-1:0] x_base_reg;
    logic [XY_MEM_DEPTH-1:0] y_tile_reg;   // y base of the current tile
    logic [W_MEM_DEPTH-1:0]  w_tile_reg;   // weight base of the current tile
    logic [LENGTH_DEPTH-1:0] len0_reg;
    logic [LENGTH_DEPTH-1:0] rem_reg;      // outputs not yet written, incl. current tile
    logic [LENGTH_DEPTH-1:0] k_reg;
    logic [LENGTH_DEPTH-1:0] j_reg;
    logic [DRAIN_W-1:0]      drain_reg;
    logic [XY_MEM_DEPTH-1:0] rd_x_reg;
    logic [W_MEM_DEPTH-1:0]  rd_w_reg;
    logic [READ_LAT-1:0]     acc_pipe_reg;

    logic                    accept;
    logic                    issue;
    logic                    abort_hit;
    logic [LENGTH_DEPTH-1:0] tile_n;
    logic                    last_k;
    logic                    last_j;
    logic                    more_tiles;

    assign accept     = (state_reg == S_IDLE) && start && !halted_reg;
    assign issue      = (state_reg == S_ACCUM);
    assign abort_hit  = abort && (state_reg != S_IDLE);
    assign tile_n     = (rem_reg > NU_L) ? NU_L : rem_reg;
    assign last_k     = (k_reg == len0_reg - ONE_L);
    assign last_j     = (j_reg == tile_n - ONE_L);
    assign more_tiles = (rem_reg > NU_L);

    // Next-state selection; abort from any busy state overrides everything.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && instruction == INS_FORWARD) begin
                    if (length0 == '0 || length1 == '0) state_next = S_DONE;
                    else                                state_next = S_LOAD;
                end
            end
            S_LOAD:  state_next = S_ACCUM;
            S_ACCUM: if (last_k) state_next = S_DRAIN;
            S_DRAIN: if (drain_reg == DRAIN_LAST) state_next = S_WRITE;
            S_WRITE: if (last_j) state_next = more_tiles ? S_LOAD : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort_hit) state_next = S_IDLE;
    end

    // State, command latch, loop counters and registered read addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            halted_reg <= 1'b0;
            x_base_reg <= '0;
            y_tile_reg <= '0;
            w_tile_reg <= '0;
            len0_reg   <= '0;
            rem_reg    <= '0;
            k_reg      <= '0;
            j_reg      <= '0;
            drain_reg  <= '0;
            rd_x_reg   <= '0;
            rd_w_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (accept && instruction == INS_FORWARD) begin
                        x_base_reg <= x_addr;
                        y_tile_reg <= y_addr;
                        w_tile_reg <= w_addr;
                        len0_reg   <= length0;
                        rem_reg    <= length1;
                    end
                    if (accept && instruction == INS_HALT) halted_reg <= 1'b1;
                end
                S_LOAD: begin
                    k_reg <= '0;
                    // Read addresses only move when an issue cycle follows.
                    if (state_next == S_ACCUM) begin
                        rd_x_reg <= x_base_reg;
                        rd_w_reg <= w_tile_reg;
                    end
                end
                S_ACCUM: begin
                    drain_reg <= '0;
                    if (state_next == S_ACCUM) begin
                        k_reg    <= k_reg + ONE_L;
                        rd_x_reg <= rd_x_reg + XY_MEM_DEPTH'(1);
                        rd_w_reg <= rd_w_reg + W_MEM_DEPTH'(1);
                    end
                end
                S_DRAIN: begin
                    drain_reg <= drain_reg + DRAIN_W'(1);
                    j_reg     <= '0;
                end
                S_WRITE: begin
                    if (!last_j) begin
                        j_reg <= j_reg + ONE_L;
                    end else begin
                        j_reg <= '0;
                        if (more_tiles) begin
                            rem_reg    <= rem_reg - NU_L;
                            y_tile_reg <= y_tile_reg + XY_MEM_DEPTH'(NU_COUNT);
                            w_tile_reg <= w_tile_reg + W_MEM_DEPTH'(len0_reg);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Issue-valid delay line feeding mac_acc_en; abort discards in-flight reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_pipe_reg <= '0;
        end else if (abort_hit) begin
            acc_pipe_reg <= '0;
        end else begin
            for (int i = READ_LAT - 1; i > 0; i--) begin
                acc_pipe_reg[i] <= acc_pipe_reg[i-1];
            end
            acc_pipe_reg[0] <= issue;
        end
    end

    // Output decode: write-side outputs are zero outside WRITE.
    always_comb begin
        busy          = (state_reg != S_IDLE) && (state_reg != S_DONE);
        done          = (state_reg == S_DONE);
        halted        = halted_reg;
        mac_clear     = (state_reg == S_LOAD);
        mac_acc_en    = acc_pipe_reg[READ_LAT-1];
        xy_read_addr  = rd_x_reg;
        w_read_addr   = rd_w_reg;
        xy_write_en   = (state_reg == S_WRITE);
        mac_sel       = '0;
        xy_write_addr = '0;
        if (state_reg == S_WRITE) begin
            mac_sel       = j_reg[SEL_W-1:0];
            xy_write_addr = y_tile_reg + XY_MEM_DEPTH'(j_reg);
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: one instance with READ_LAT=1 and one
// with READ_LAT=3. Each command is stepped cycle by cycle; outputs are
// captured on the falling edge into per-cycle arrays (cycle 1 = the cycle
// after the start edge) and compared against hand-computed values.
module tb_matmul_sequencer;

    localparam int XW = 8;
    localparam int WW = 10;
    localparam int LW = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          start3;
    logic          abort;
    logic [1:0]    instruction;
    logic [XW-1:0] x_addr;
    logic [XW-1:0] y_addr;
    logic [WW-1:0] w_addr;
    logic [LW-1:0] length0;
    logic [LW-1:0] length1;

    logic          busy, done, halted, mac_clear, mac_acc_en, xy_write_en;
    logic [XW-1:0] xy_read_addr, xy_write_addr;
    logic [WW-1:0] w_read_addr;
    logic [SW-1:0] mac_sel;

    logic          busy3, done3, halted3, mac_clear3, mac_acc_en3, xy_write_en3;
    logic [XW-1:0] xy_read_addr3, xy_write_addr3;
    logic [WW-1:0] w_read_addr3;
    logic [SW-1:0] mac_sel3;

    always #5 clk = ~clk;

    matmul_sequencer #(.NU_COUNT(4), .XY_MEM_DEPTH(XW), .W_MEM_DEPTH(WW),
                       .LENGTH_DEPTH(LW), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .x_addr(x_addr), .y_addr(y_addr), .w_addr(w_addr),
        .length0(length0), .length1(length1), .abort(abort),
        .busy(busy), .done(done), .halted(halted),
        .xy_read_addr(xy_read_addr), .w_read_addr(w_read_addr),
        .mac_clear(mac_clear), .mac_acc_en(mac_acc_en), .mac_sel(mac_sel),
        .xy_write_addr(xy_write_addr), .xy_write_en(xy_write_en)
    );

    matmul_sequencer #(.NU_COUNT(4), .XY_MEM_DEPTH(XW), .W_MEM_DEPTH(WW),
                       .LENGTH_DEPTH(LW), .READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .instruction(instruction),
        .x_addr(x_addr), .y_addr(y_addr), .w_addr(w_addr),
        .length0(length0), .length1(length1), .abort(abort),
        .busy(busy3), .done(done3), .halted(halted3),
        .xy_read_addr(xy_read_addr3), .w_read_addr(w_read_addr3),
        .mac_clear(mac_clear3), .mac_acc_en(mac_acc_en3), .mac_sel(mac_sel3),
        .xy_write_addr(xy_write_addr3), .xy_write_en(xy_write_en3)
    );

    int total = 0;
    int bad   = 0;

    // per-cycle capture of the selected instance
    int cyc;
    bit use3;
    int clr_a[0:39];
    int acc_a[0:39];
    int we_a[0:39];
    int wa_a[0:39];
    int sel_a[0:39];
    int xa_a[0:39];
    int wra_a[0:39];
    int dn_a[0:39];
    int bz_a[0:39];
    int nwr, ndone, nclr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic begin_cmd(input logic [1:0] ins, input int x, input int y, input int w,
                             input int l0, input int l1, input bit on3);
        instruction = ins;
        x_addr  = XW'(x);
        y_addr  = XW'(y);
        w_addr  = WW'(w);
        length0 = LW'(l0);
        length1 = LW'(l1);
        if (on3) start3 = 1'b1;
        else     start  = 1'b1;
        use3  = on3;
        cyc   = 0;
        nwr   = 0;
        ndone = 0;
        nclr  = 0;
        for (int i = 0; i < 40; i++) begin
            clr_a[i] = 0; acc_a[i] = 0; we_a[i] = 0; wa_a[i] = 0; sel_a[i] = 0;
            xa_a[i] = 0; wra_a[i] = 0; dn_a[i] = 0; bz_a[i] = 0;
        end
    endtask

    // Advance one cycle, capture outputs mid-cycle, then drop any start pulse.
    task automatic step();
        @(negedge clk);
        if (cyc < 39) cyc++;
        if (!use3) begin
            clr_a[cyc] = int'(mac_clear);    acc_a[cyc] = int'(mac_acc_en);
            we_a[cyc]  = int'(xy_write_en);  wa_a[cyc]  = int'(xy_write_addr);
            sel_a[cyc] = int'(mac_sel);      xa_a[cyc]  = int'(xy_read_addr);
            wra_a[cyc] = int'(w_read_addr);  dn_a[cyc]  = int'(done);
            bz_a[cyc]  = int'(busy);
        end else begin
            clr_a[cyc] = int'(mac_clear3);   acc_a[cyc] = int'(mac_acc_en3);
            we_a[cyc]  = int'(xy_write_en3); wa_a[cyc]  = int'(xy_write_addr3);
            sel_a[cyc] = int'(mac_sel3);     xa_a[cyc]  = int'(xy_read_addr3);
            wra_a[cyc] = int'(w_read_addr3); dn_a[cyc]  = int'(done3);
            bz_a[cyc]  = int'(busy3);
        end
        nwr   += we_a[cyc];
        ndone += dn_a[cyc];
        nclr  += clr_a[cyc];
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic report(input string name);
        $display("cmd %s: cycles=%0d writes=%0d clears=%0d done_pulses=%0d",
                 name, cyc, nwr, nclr, ndone);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start3 = 1'b0; abort = 1'b0;
        instruction = 2'd3; x_addr = '0; y_addr = '0; w_addr = '0;
        length0 = '0; length1 = '0;
        use3 = 1'b0; cyc = 0; nwr = 0; ndone = 0; nclr = 0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_xa",     xy_read_addr, 0);
        chk("rst_wra",    w_read_addr, 0);
        chk("rst_we",     xy_write_en, 0);
        chk("rst_acc3",   mac_acc_en3, 0);
        reset = 1'b1;
        @(negedge clk);

        // single tile: x=2 y=0 w=12 L0=4 L1=2
        begin_cmd(2'd1, 2, 0, 12, 4, 2, 1'b0);
        steps(12);
        report("fwd_l0_4_l1_2");
        chk("t1_clr1", clr_a[1], 1);
        chk("t1_busy1", bz_a[1], 1);
        for (int c = 2; c <= 5; c++) begin
            chk($sformatf("t1_xa%0d", c), xa_a[c], 2 + c - 2);
            chk($sformatf("t1_wra%0d", c), wra_a[c], 12 + c - 2);
        end
        chk("t1_acc2", acc_a[2], 0);
        for (int c = 3; c <= 6; c++) chk($sformatf("t1_acc%0d", c), acc_a[c], 1);
        chk("t1_acc7", acc_a[7], 0);
        chk("t1_xa_hold6", xa_a[6], 5);
        chk("t1_wra_hold6", wra_a[6], 15);
        chk("t1_we6", we_a[6], 0);
        chk("t1_we7", we_a[7], 1);
        chk("t1_wa7", wa_a[7], 0);
        chk("t1_sel7", sel_a[7], 0);
        chk("t1_we8", we_a[8], 1);
        chk("t1_wa8", wa_a[8], 1);
        chk("t1_sel8", sel_a[8], 1);
        chk("t1_busy8", bz_a[8], 1);
        chk("t1_done9", dn_a[9], 1);
        chk("t1_busy9", bz_a[9], 0);
        chk("t1_nwr", nwr, 2);
        chk("t1_ndone", ndone, 1);

        // two tiles L1=6, with a stray start during ACCUM
        begin_cmd(2'd1, 2, 0, 12, 4, 6, 1'b0);
        steps(3);
        start = 1'b1; x_addr = 8'd50; w_addr = 10'd300; length0 = 8'd1;
        steps(18);
        report("fwd_l0_4_l1_6");
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t2_wa%0d", 7 + j), wa_a[7 + j], j);
            chk($sformatf("t2_sel%0d", 7 + j), sel_a[7 + j], j);
        end
        chk("t2_xa4", xa_a[4], 4);
        chk("t2_clr11", clr_a[11], 1);
        for (int c = 12; c <= 15; c++) begin
            chk($sformatf("t2_wra%0d", c), wra_a[c], 16 + c - 12);
            chk($sformatf("t2_xa%0d", c), xa_a[c], 2 + c - 12);
        end
        chk("t2_wa17", wa_a[17], 4);
        chk("t2_sel17", sel_a[17], 0);
        chk("t2_wa18", wa_a[18], 5);
        chk("t2_sel18", sel_a[18], 1);
        chk("t2_done19", dn_a[19], 1);
        chk("t2_nwr", nwr, 6);
        chk("t2_nclr", nclr, 2);
        chk("t2_ndone", ndone, 1);

        // READ_LAT=3 instance: x=10 y=20 w=5 L0=2 L1=1
        begin_cmd(2'd1, 10, 20, 5, 2, 1, 1'b1);
        steps(10);
        report("rl3_l0_2_l1_1");
        chk("t3_xa2", xa_a[2], 10);
        chk("t3_xa3", xa_a[3], 11);
        chk("t3_wra3", wra_a[3], 6);
        chk("t3_acc4", acc_a[4], 0);
        chk("t3_acc5", acc_a[5], 1);
        chk("t3_acc6", acc_a[6], 1);
        chk("t3_acc7", acc_a[7], 0);
        chk("t3_busy6", bz_a[6], 1);
        chk("t3_we6", we_a[6], 0);
        chk("t3_we7", we_a[7], 1);
        chk("t3_wa7", wa_a[7], 20);
        chk("t3_done8", dn_a[8], 1);
        chk("t3_nwr", nwr, 1);

        // zero-length commands
        begin_cmd(2'd1, 1, 1, 1, 0, 3, 1'b0);
        steps(4);
        report("fwd_l0_0");
        chk("t4_done1", dn_a[1], 1);
        chk("t4_busy1", bz_a[1], 0);
        chk("t4_nwr", nwr, 0);
        chk("t4_nclr", nclr, 0);
        chk("t4_ndone", ndone, 1);
        begin_cmd(2'd1, 1, 1, 1, 5, 0, 1'b0);
        steps(4);
        report("fwd_l1_0");
        chk("t4b_done1", dn_a[1], 1);
        chk("t4b_nclr", nclr, 0);

        // abort during ACCUM, then immediate restart
        begin_cmd(2'd1, 2, 0, 12, 4, 6, 1'b0);
        steps(3);
        chk("t5_acc3", acc_a[3], 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        report("fwd_abort");
        chk("t5_busy4", bz_a[4], 0);
        chk("t5_acc4", acc_a[4], 0);
        chk("t5_nwr", nwr, 0);
        chk("t5_ndone", ndone, 0);
        begin_cmd(2'd1, 7, 9, 3, 1, 1, 1'b0);
        steps(7);
        report("fwd_after_abort");
        chk("t5r_clr1", clr_a[1], 1);
        chk("t5r_busy1", bz_a[1], 1);
        chk("t5r_xa2", xa_a[2], 7);
        chk("t5r_wra2", wra_a[2], 3);
        chk("t5r_acc3", acc_a[3], 1);
        chk("t5r_wa4", wa_a[4], 9);
        chk("t5r_done5", dn_a[5], 1);
        chk("t5r_nwr", nwr, 1);
        chk("t5r_ndone", ndone, 1);

        // HALT, ignored FORWARD, then reset clears halted
        begin_cmd(2'd0, 0, 0, 0, 4, 2, 1'b0);
        steps(3);
        report("halt");
        chk("t6_halted", halted, 1);
        chk("t6_busy1", bz_a[1], 0);
        chk("t6_ndone", ndone, 0);
        begin_cmd(2'd1, 2, 0, 12, 4, 2, 1'b0);
        steps(5);
        report("fwd_while_halted");
        chk("t6_ign_busy1", bz_a[1], 0);
        chk("t6_ign_nclr", nclr, 0);
        chk("t6_ign_nwr", nwr, 0);
        reset = 1'b0;
        #1;
        chk("t6_rst_halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;
        begin_cmd(2'd1, 2, 0, 12, 4, 2, 1'b0);
        steps(12);
        report("fwd_after_reset");
        chk("t6_xa5", xa_a[5], 5);
        chk("t6_wa8", wa_a[8], 1);
        chk("t6_done9", dn_a[9], 1);
        chk("t6_nwr", nwr, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
